// File: rtl/rab_lookup_ctrl_if.sv
// Request, slice-array, master, error and miss-log signals of one RAB port
// lookup stage. The slave modport is the lookup controller's view; the
// master modport is the view of whatever surrounds it.
interface rab_lookup_ctrl_if #(
    parameter int RAB_ENTRIES = 16,
    parameter int ID_WIDTH    = 4
);
    // incoming address-channel request
    logic [31:0]            s_addr;
    logic [ID_WIDTH-1:0]    s_id;
    logic [7:0]             s_len;
    logic [2:0]             s_size;
    logic                   s_rw;
    logic                   s_valid;
    logic                   s_ready;
    // slice array lookup
    logic                   lkp_rw;
    logic [31:0]            lkp_addr_min;
    logic [31:0]            lkp_addr_max;
    logic [RAB_ENTRIES-1:0] lkp_hit;
    logic [RAB_ENTRIES-1:0] lkp_prot;
    logic                   lkp_multi_hit;
    logic                   lkp_master_select;
    logic [31:0]            lkp_out_addr;
    // translated request
    logic [31:0]            m_addr;
    logic [ID_WIDTH-1:0]    m_id;
    logic [7:0]             m_len;
    logic [2:0]             m_size;
    logic                   m_rw;
    logic                   m_master_select;
    logic                   m_valid;
    logic                   m_ready;
    // error-response path
    logic [ID_WIDTH-1:0]    err_id;
    logic                   err_rw;
    logic [7:0]             err_len;
    logic [1:0]             err_code;
    logic                   err_valid;
    logic                   err_ready;
    // miss log
    logic [31:0]            miss_addr;
    logic [ID_WIDTH-1:0]    miss_id;
    logic                   miss_rw;
    logic                   miss_pop;
    logic                   miss_empty;
    logic                   miss_full;
    logic                   miss_ovf;
    logic                   miss_ovf_clr;
    // interrupts
    logic                   irq_miss;
    logic                   irq_prot;
    logic                   irq_multi;

    modport slave (
        input  s_addr, s_id, s_len, s_size, s_rw, s_valid,
        output s_ready,
        output lkp_rw, lkp_addr_min, lkp_addr_max,
        input  lkp_hit, lkp_prot, lkp_multi_hit, lkp_master_select, lkp_out_addr,
        output m_addr, m_id, m_len, m_size, m_rw, m_master_select, m_valid,
        input  m_ready,
        output err_id, err_rw, err_len, err_code, err_valid,
        input  err_ready,
        output miss_addr, miss_id, miss_rw, miss_empty, miss_full, miss_ovf,
        input  miss_pop, miss_ovf_clr,
        output irq_miss, irq_prot, irq_multi
    );

    modport master (
        output s_addr, s_id, s_len, s_size, s_rw, s_valid,
        input  s_ready,
        input  lkp_rw, lkp_addr_min, lkp_addr_max,
        output lkp_hit, lkp_prot, lkp_multi_hit, lkp_master_select, lkp_out_addr,
        input  m_addr, m_id, m_len, m_size, m_rw, m_master_select, m_valid,
        output m_ready,
        input  err_id, err_rw, err_len, err_code, err_valid,
        output err_ready,
        input  miss_addr, miss_id, miss_rw, miss_empty, miss_full, miss_ovf,
        output miss_pop, miss_ovf_clr,
        input  irq_miss, irq_prot, irq_multi
    );
endinterface

// File: rtl/rab_lookup_ctrl.sv
// RAB port request-side lookup control: one request in flight, burst range
// computed up front, slice-array result classified in a single LOOKUP cycle,
// then either forwarded translated or handed to the error path. Misses are
// logged in a small FIFO with a sticky overflow flag.
module rab_lookup_ctrl #(
    parameter int RAB_ENTRIES     = 16,
    parameter int ID_WIDTH        = 4,
    parameter int MISS_FIFO_DEPTH = 4
) (
    input logic             axi4_aclk,
    input logic             axi4_areset,
    rab_lookup_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(MISS_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + ID_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, FWD, ERR} state_e;

    state_e state_q, state_d;

    logic [31:0]          addr_min_q, addr_max_q;
    logic                 wrap_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic                 rw_q;
    logic [31:0]          m_addr_q;
    logic                 m_ms_q;
    logic [1:0]           err_code_q;
    logic                 irq_miss_q, irq_prot_q, irq_multi_q;

    logic [ENT_W-1:0]     mem_q [MISS_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 full_q, empty_q, ovf_q;

    logic [RAB_ENTRIES-1:0] hit_w, prot_w;
    logic [16:0]          bytes_w;
    logic [32:0]          sum_w;
    logic                 take_hit, take_miss, take_prot, take_multi;
    logic                 accept_w, pop_w, push_ok_w;

    assign hit_w    = bus.lkp_hit;
    assign prot_w   = bus.lkp_prot;
    assign accept_w = (state_q == IDLE) && bus.s_valid;

    // Burst byte span and inclusive end address; bit 32 flags a wrap past 4 GiB.
    always_comb begin
        bytes_w = ({9'd0, bus.s_len} + 17'd1) << bus.s_size;
        sum_w   = {1'b0, bus.s_addr} + {16'd0, bytes_w} - 33'd1;
    end

    // State register.
    always_ff @(posedge axi4_aclk or posedge axi4_areset) begin
        if (axi4_areset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic and LOOKUP result classification in priority order.
    always_comb begin
        state_d    = state_q;
        take_hit   = 1'b0;
        take_miss  = 1'b0;
        take_prot  = 1'b0;
        take_multi = 1'b0;
        case (state_q)
            IDLE:   if (bus.s_valid) state_d = LOOKUP;
            LOOKUP: begin
                if (wrap_q)                 take_miss  = 1'b1;
                else if (bus.lkp_multi_hit) take_multi = 1'b1;
                else if (|hit_w)            take_hit   = 1'b1;
                else if (|prot_w)           take_prot  = 1'b1;
                else                        take_miss  = 1'b1;
                state_d = take_hit ? FWD : ERR;
            end
            FWD:    if (bus.m_ready)   state_d = IDLE;
            ERR:    if (bus.err_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the accepted request and its address range.
    always_ff @(posedge axi4_aclk or posedge axi4_areset) begin
        if (axi4_areset) begin
            addr_min_q <= '0;
            addr_max_q <= '0;
            wrap_q     <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            rw_q       <= 1'b0;
        end else if (accept_w) begin
            addr_min_q <= bus.s_addr;
            addr_max_q <= sum_w[31:0];
            wrap_q     <= sum_w[32];
            id_q       <= bus.s_id;
            len_q      <= bus.s_len;
            size_q     <= bus.s_size;
            rw_q       <= bus.s_rw;
        end
    end

    // Register the lookup outcome: translation, error code and irq pulses.
    always_ff @(posedge axi4_aclk or posedge axi4_areset) begin
        if (axi4_areset) begin
            m_addr_q    <= '0;
            m_ms_q      <= 1'b0;
            err_code_q  <= '0;
            irq_miss_q  <= 1'b0;
            irq_prot_q  <= 1'b0;
            irq_multi_q <= 1'b0;
        end else begin
            if (take_hit) begin
                m_addr_q <= bus.lkp_out_addr;
                m_ms_q   <= bus.lkp_master_select;
            end
            if (take_miss)  err_code_q <= 2'd1;
            if (take_prot)  err_code_q <= 2'd2;
            if (take_multi) err_code_q <= 2'd3;
            irq_miss_q  <= take_miss;
            irq_prot_q  <= take_prot;
            irq_multi_q <= take_multi;
        end
    end

    // A push into a full log only lands when a pop frees a slot the same edge.
    always_comb begin
        pop_w     = bus.miss_pop && !empty_q;
        push_ok_w = take_miss && (!full_q || pop_w);
        cnt_d     = cnt_q + CNT_W'(push_ok_w) - CNT_W'(pop_w);
    end

    // Miss log storage, pointers, registered flags and sticky overflow.
    always_ff @(posedge axi4_aclk or posedge axi4_areset) begin
        if (axi4_areset) begin
            for (int i = 0; i < MISS_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_w) begin
                mem_q[wr_ptr_q] <= {addr_min_q, id_q, rw_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(MISS_FIFO_DEPTH));
            empty_q <= (cnt_d == '0);
            if (take_miss && full_q && !pop_w) ovf_q <= 1'b1;
            else if (bus.miss_ovf_clr)         ovf_q <= 1'b0;
        end
    end

    assign bus.s_ready          = (state_q == IDLE) && !axi4_areset;
    assign bus.lkp_rw           = rw_q;
    assign bus.lkp_addr_min     = addr_min_q;
    assign bus.lkp_addr_max     = addr_max_q;
    assign bus.m_addr           = m_addr_q;
    assign bus.m_id             = id_q;
    assign bus.m_len            = len_q;
    assign bus.m_size           = size_q;
    assign bus.m_rw             = rw_q;
    assign bus.m_master_select  = m_ms_q;
    assign bus.m_valid          = (state_q == FWD);
    assign bus.err_id           = id_q;
    assign bus.err_rw           = rw_q;
    assign bus.err_len          = len_q;
    assign bus.err_code         = err_code_q;
    assign bus.err_valid        = (state_q == ERR);
    assign {bus.miss_addr, bus.miss_id, bus.miss_rw} = mem_q[rd_ptr_q];
    assign bus.miss_empty       = empty_q;
    assign bus.miss_full        = full_q;
    assign bus.miss_ovf         = ovf_q;
    assign bus.irq_miss         = irq_miss_q;
    assign bus.irq_prot         = irq_prot_q;
    assign bus.irq_multi        = irq_multi_q;
endmodule

// File: tb/tb_rab_lookup_ctrl.sv
// Directed bench for rab_lookup_ctrl: hit, miss with backpressure, prot,
// multi-hit, wrap, miss-log overflow and reset in the middle of a forward.
module tb_rab_lookup_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rab_lookup_ctrl_if #(.RAB_ENTRIES(16), .ID_WIDTH(4)) bus ();

    rab_lookup_ctrl #(
        .RAB_ENTRIES(16),
        .ID_WIDTH(4),
        .MISS_FIFO_DEPTH(4)
    ) dut (
        .axi4_aclk  (clk),
        .axi4_areset(rst),
        .bus        (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for one edge; returns at the negedge of LOOKUP.
    task automatic issue(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size, input logic rw);
        bus.s_addr  = addr;
        bus.s_id    = id;
        bus.s_len   = len;
        bus.s_size  = size;
        bus.s_rw    = rw;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic finish_err();
        bus.err_ready = 1'b1;
        step();
        bus.err_ready = 1'b0;
    endtask

    function automatic logic [2:0] irqs();
        return {bus.irq_miss, bus.irq_prot, bus.irq_multi};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.s_addr = '0; bus.s_id = '0; bus.s_len = '0; bus.s_size = '0; bus.s_rw = 1'b0;
        bus.s_valid = 1'b0;
        bus.lkp_hit = '0; bus.lkp_prot = '0; bus.lkp_multi_hit = 1'b0;
        bus.lkp_master_select = 1'b0; bus.lkp_out_addr = '0;
        bus.m_ready = 1'b0; bus.err_ready = 1'b0;
        bus.miss_pop = 1'b0; bus.miss_ovf_clr = 1'b0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready",   bus.s_ready, 0);
        chk("rst_m_valid",   bus.m_valid, 0);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_irq",       irqs(), 0);
        chk("rst_empty",     bus.miss_empty, 1);
        chk("rst_full",      bus.miss_full, 0);
        chk("rst_ovf",       bus.miss_ovf, 0);
        chk("rst_lkp_max",   bus.lkp_addr_max, 0);
        chk("rst_m_addr",    bus.m_addr, 0);
        chk("rst_miss_addr", bus.miss_addr, 0);
        rst = 1'b0;
        #1;
        chk("rel_s_ready", bus.s_ready, 1);
        @(negedge clk);

        // single hit on slice 2
        bus.lkp_hit = 16'h0004;
        bus.lkp_out_addr = 32'h8000_0040;
        bus.lkp_master_select = 1'b1;
        issue(32'h1000_0040, 4'd3, 8'd3, 3'd2, 1'b0);
        chk("hit_lkp_min", bus.lkp_addr_min, 32'h1000_0040);
        chk("hit_lkp_max", bus.lkp_addr_max, 32'h1000_004F);
        chk("hit_lkp_rw",  bus.lkp_rw, 0);
        chk("hit_sready_lkp", bus.s_ready, 0);
        chk("hit_mvalid_lkp", bus.m_valid, 0);
        step();
        chk("hit_m_valid", bus.m_valid, 1);
        chk("hit_m_addr",  bus.m_addr, 32'h8000_0040);
        chk("hit_m_id",    bus.m_id, 3);
        chk("hit_m_len",   bus.m_len, 3);
        chk("hit_m_size",  bus.m_size, 2);
        chk("hit_m_ms",    bus.m_master_select, 1);
        chk("hit_irq",     irqs(), 0);
        chk("hit_err_valid", bus.err_valid, 0);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("hit_m_valid_done", bus.m_valid, 0);
        chk("hit_s_ready_done", bus.s_ready, 1);

        // miss with error-side backpressure
        bus.lkp_hit = '0;
        issue(32'h1000_0040, 4'd5, 8'd3, 3'd2, 1'b1);
        step();
        chk("miss_err_valid", bus.err_valid, 1);
        chk("miss_code",   bus.err_code, 1);
        chk("miss_irq",    irqs(), 3'b100);
        chk("miss_err_id", bus.err_id, 5);
        chk("miss_err_rw", bus.err_rw, 1);
        chk("miss_err_len", bus.err_len, 3);
        chk("miss_fifo_empty", bus.miss_empty, 0);
        chk("miss_fifo_addr", bus.miss_addr, 32'h1000_0040);
        chk("miss_fifo_id",   bus.miss_id, 5);
        chk("miss_fifo_rw",   bus.miss_rw, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("miss_hold_valid", bus.err_valid, 1);
            chk("miss_hold_code",  bus.err_code, 1);
            chk("miss_hold_irq",   irqs(), 0);
            chk("miss_hold_sready", bus.s_ready, 0);
        end
        finish_err();
        chk("miss_err_done", bus.err_valid, 0);
        chk("miss_sready_done", bus.s_ready, 1);

        // protection fault
        bus.lkp_prot = 16'h0020;
        issue(32'h1000_0080, 4'd6, 8'd0, 3'd0, 1'b0);
        step();
        chk("prot_code", bus.err_code, 2);
        chk("prot_irq",  irqs(), 3'b010);
        finish_err();

        // multi-hit: sentinel translation must not reach m_addr
        bus.lkp_prot = '0;
        bus.lkp_hit = 16'h0003;
        bus.lkp_multi_hit = 1'b1;
        bus.lkp_out_addr = 32'hDEAD_BEEF;
        issue(32'h1000_00C0, 4'd7, 8'd0, 3'd0, 1'b0);
        step();
        chk("multi_code", bus.err_code, 3);
        chk("multi_irq",  irqs(), 3'b001);
        chk("multi_m_addr", bus.m_addr, 32'h8000_0040);
        chk("multi_m_valid", bus.m_valid, 0);
        finish_err();
        // only the earlier miss was logged
        bus.miss_pop = 1'b1;
        step();
        bus.miss_pop = 1'b0;
        chk("pm_fifo_empty", bus.miss_empty, 1);

        // wrapping burst forced to miss despite a hit
        bus.lkp_multi_hit = 1'b0;
        bus.lkp_hit = 16'h0004;
        bus.lkp_out_addr = 32'h8000_0000;
        issue(32'hFFFF_FFF0, 4'd1, 8'd7, 3'd2, 1'b0);
        chk("wrap_lkp_max", bus.lkp_addr_max, 32'h0000_000F);
        step();
        chk("wrap_code", bus.err_code, 1);
        chk("wrap_irq",  irqs(), 3'b100);
        chk("wrap_m_valid", bus.m_valid, 0);
        finish_err();
        chk("wrap_fifo_addr", bus.miss_addr, 32'hFFFF_FFF0);
        bus.miss_pop = 1'b1;
        step();
        bus.miss_pop = 1'b0;
        chk("wrap_fifo_empty", bus.miss_empty, 1);
        // pop on empty is ignored
        bus.miss_pop = 1'b1;
        step();
        bus.miss_pop = 1'b0;
        chk("empty_pop_empty", bus.miss_empty, 1);
        chk("empty_pop_full",  bus.miss_full, 0);

        // miss-log overflow
        bus.lkp_hit = '0;
        for (int i = 0; i < 5; i++) begin
            issue(32'h2000_0000 + 32'(i) * 32'h100, 4'(i), 8'd0, 3'd0, 1'b0);
            step();
            finish_err();
            if (i == 2) chk("ovf_full_3", bus.miss_full, 0);
            if (i == 3) begin
                chk("ovf_full_4", bus.miss_full, 1);
                chk("ovf_ovf_4",  bus.miss_ovf, 0);
            end
        end
        chk("ovf_set", bus.miss_ovf, 1);
        chk("ovf_full_5", bus.miss_full, 1);
        chk("ovf_head", bus.miss_addr, 32'h2000_0000);
        // sixth miss pushed while popping a full log
        issue(32'h2000_0500, 4'd9, 8'd0, 3'd0, 1'b0);
        bus.miss_pop = 1'b1;
        step();
        bus.miss_pop = 1'b0;
        chk("ovf_pp_head", bus.miss_addr, 32'h2000_0100);
        chk("ovf_pp_full", bus.miss_full, 1);
        chk("ovf_pp_ovf",  bus.miss_ovf, 1);
        finish_err();
        bus.miss_ovf_clr = 1'b1;
        step();
        bus.miss_ovf_clr = 1'b0;
        chk("ovf_clr", bus.miss_ovf, 0);
        bus.miss_pop = 1'b1;
        step();
        step();
        step();
        bus.miss_pop = 1'b0;
        chk("ovf_tail_addr", bus.miss_addr, 32'h2000_0500);
        chk("ovf_tail_id",   bus.miss_id, 9);
        chk("ovf_tail_full", bus.miss_full, 0);
        chk("ovf_tail_empty", bus.miss_empty, 0);

        // reset while forwarding
        bus.lkp_hit = 16'h0004;
        bus.lkp_out_addr = 32'h8000_1000;
        issue(32'h1000_1000, 4'd2, 8'd0, 3'd0, 1'b0);
        step();
        chk("rfwd_m_valid", bus.m_valid, 1);
        rst = 1'b1;
        #1;
        chk("rfwd_m_valid_drop", bus.m_valid, 0);
        chk("rfwd_empty", bus.miss_empty, 1);
        chk("rfwd_s_ready_rst", bus.s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rfwd_s_ready_rel", bus.s_ready, 1);
        chk("rfwd_m_valid_rel", bus.m_valid, 0);
        chk("rfwd_m_addr_rel", bus.m_addr, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rab_lookup_ctrl.md
# rab_lookup_ctrl

Request-side control stage sitting directly upstream of the slice array in the RAB port. Accepts one AXI address-channel request at a time, computes the burst address range, drives the slice array's lookup inputs, registers the returned hit/protection/translation result, and either forwards the translated request to the master side or routes it to the error-response path. Translation misses are recorded in a small miss FIFO for software handling.

## Interface
- RAB_ENTRIES, 16, slices in the array (width of hit/prot vectors)
- ID_WIDTH, 4, AXI ID width
- MISS_FIFO_DEPTH, 4, miss-log entries (power of two, ≥2)
- axi4_aclk  in  1  clock
- axi4_areset  in  1  reset; one clock, reset asynchronous and active-high
- s_addr / s_id / s_len / s_size / s_rw  in  32 / ID_WIDTH / 8 / 3 / 1  incoming request (s_rw=1 write)
- s_valid  in  1 ; s_ready  out  1  request handshake
- lkp_rw  out  1 ; lkp_addr_min  out  32 ; lkp_addr_max  out  32  to slice array
- lkp_hit  in  RAB_ENTRIES ; lkp_prot  in  RAB_ENTRIES ; lkp_multi_hit  in  1 ; lkp_master_select  in  1 ; lkp_out_addr  in  32  slice array result (combinational)
- m_addr / m_id / m_len / m_size / m_rw / m_master_select  out  32 / ID_WIDTH / 8 / 3 / 1 / 1  translated request
- m_valid  out  1 ; m_ready  in  1
- err_id / err_rw / err_len  out  ID_WIDTH / 1 / 8 ; err_code  out  2 (1 miss, 2 prot, 3 multi) ; err_valid  out  1 ; err_ready  in  1
- miss_addr / miss_id / miss_rw  out  32 / ID_WIDTH / 1  FIFO head
- miss_pop  in  1 ; miss_empty  out  1 ; miss_full  out  1
- miss_ovf  out  1  sticky overflow ; miss_ovf_clr  in  1
- irq_miss / irq_prot / irq_multi  out  1  single-cycle pulses

## Operation
- FSM states IDLE, LOOKUP, FWD, ERR. Reset state IDLE.
- IDLE: s_ready=1. On s_valid: register request fields, compute range, go LOOKUP.
- Range: addr_min = s_addr; bytes = (s_len+1) << s_size; addr_max = s_addr + bytes − 1, computed 33 bits wide. Carry into bit 32 sets a registered `wrap` flag.
- lkp_* driven from the registered request only, stable through LOOKUP.
- LOOKUP (exactly one cycle): sample result. Priority: wrap → MISS; lkp_multi_hit → MULTI; |lkp_hit → translate; |lkp_prot → PROT; else MISS.
- Translate: m_addr = lkp_out_addr, m_master_select = lkp_master_select, other m_* = registered fields; go FWD.
- Error: load err_* and err_code; go ERR. Pulse matching irq_* in the cycle after LOOKUP.
- MISS additionally pushes {addr_min, id, rw} into the miss FIFO; if full (and no same-cycle pop), drop entry and set miss_ovf. irq_miss pulses regardless.
- FWD: m_valid=1, hold all m_* until m_ready; then IDLE.
- ERR: err_valid=1, hold err_* until err_ready; then IDLE.
- Miss FIFO: head visible on miss_*; miss_pop with !miss_empty advances. Pop on empty ignored. Simultaneous push and pop when full: both succeed, miss_ovf unchanged.
- miss_ovf cleared by miss_ovf_clr; a same-cycle set wins over clear.
- The sentinel 0xDEADBEEF on lkp_out_addr is never forwarded (only consumed when a single hit exists).

## Timing
- Reset values: s_ready=0 during reset, 1 in the first cycle after deassertion; m_valid, err_valid, irq_* = 0; m_*/err_*/lkp_* data = 0; miss_empty=1, miss_full=0, miss_ovf=0, miss_* = 0.
- Reset asserted mid-transaction: the pending request is discarded, FIFO is emptied, and no partial handshake completes.
- s handshake at edge E0 → LOOKUP cycle → m_valid or err_valid high from edge E1 (latency 2 edges to earliest downstream handshake at E2).
- s_ready returns to 1 the cycle after the downstream handshake; max throughput one request per 3 cycles.
- m_valid/err_valid never deassert without handshake; payload stable while valid.
- miss FIFO: push visible on miss_* one cycle after the push edge; miss_full/miss_empty are registered.

## Test plan
- Single hit: s_addr=0x1000_0040, len=3, size=2, slice 2 hits with lkp_out_addr=0x8000_0040 → lkp_addr_max=0x1000_004F; m_valid at E1 with m_addr=0x8000_0040; no irq.
- Miss with backpressure: no hit, no prot, err_ready=0 for 5 cycles → err_code=1 held stable; irq_miss one pulse; FIFO holds 0x1000_0040; s_ready=0 until err handshake.
- Prot and multi: lkp_prot[5]=1, no hit → err_code=2, irq_prot; then lkp_multi_hit=1 → err_code=3, irq_multi, no FIFO push.
- Wrap: s_addr=0xFFFF_FFF0, len=7, size=2 → wrap set, err_code=1 even with lkp_hit=1.
- FIFO overflow: 5 misses with DEPTH=4 and no pops → miss_full after 4th; 5th sets miss_ovf; miss_pop concurrent with a 6th push when full → accepted, miss_ovf unchanged; miss_ovf_clr clears it.
- Reset mid-FWD: assert axi4_areset while m_valid=1 → m_valid drops immediately, FIFO empty, s_ready=1 after release.
